// File: rtl/pb_gesture_decoder.sv
// Push-button gesture decoder: turns debounced press/release events into short, long, double and repeat pulses.
// Optional macro PB_GESTURE_REPEAT_EN enables auto-repeat pulses during a long hold.
module pb_gesture_decoder #(
    parameter int LONG_CYCLES   = 500,
    parameter int DCLICK_CYCLES = 200,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed_pulse,
    input  logic released_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse,
    output logic busy
);

    // state     | meaning
    // IDLE      | no gesture in progress, waiting for a press
    // HELD      | first press down, timing towards a long press
    // GAP       | first press released, waiting for a second press
    // WAIT_REL  | double click reported, waiting for the second release
    // LONG_HELD | long press reported, waiting for release (repeat ticks if enabled)

    localparam int MAX_AB = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
    localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int TW     = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HELD      = 3'd1,
        GAP       = 3'd2,
        WAIT_REL  = 3'd3,
        LONG_HELD = 3'd4
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] timer;
    logic          restart;
    logic          press_eff;
    logic          short_n;
    logic          long_n;
    logic          double_n;
`ifdef PB_GESTURE_REPEAT_EN
    logic          repeat_n;
`endif

    // A press coinciding with a release is treated as noise and dropped.
    assign press_eff = pressed_pulse & ~released_pulse;

    always_comb begin
        state_n  = state;
        restart  = 1'b0;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
`ifdef PB_GESTURE_REPEAT_EN
        repeat_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (press_eff) state_n = HELD;
            end
            HELD: begin
                if (released_pulse) begin
                    state_n = GAP;
                end else if (timer == TW'(LONG_CYCLES - 1)) begin
                    state_n = LONG_HELD;
                    long_n  = 1'b1;
                end
            end
            GAP: begin
                if (press_eff) begin
                    state_n  = WAIT_REL;
                    double_n = 1'b1;
                end else if (timer == TW'(DCLICK_CYCLES - 1)) begin
                    state_n = IDLE;
                    short_n = 1'b1;
                end
            end
            WAIT_REL: begin
                if (released_pulse) state_n = IDLE;
            end
            LONG_HELD: begin
                if (released_pulse) begin
                    state_n = IDLE;
`ifdef PB_GESTURE_REPEAT_EN
                end else if (timer == TW'(REPEAT_CYCLES - 1)) begin
                    repeat_n = 1'b1;
                    restart  = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            short_pulse  <= short_n;
            long_pulse   <= long_n;
            double_pulse <= double_n;
            if ((state_n != state) || restart) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

`ifdef PB_GESTURE_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_n;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: doc/pb_gesture_decoder.md
PB_GESTURE_DECODER -- requirements
Module: pb_gesture_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Parameter LONG_CYCLES, default 500, SHALL set the hold time in cycles that qualifies a long press; legal range is 2 or more.
REQ-003 Parameter DCLICK_CYCLES, default 200, SHALL set the maximum release-to-press gap in cycles for a double click; legal range is 2 or more.
REQ-004 Parameter REPEAT_CYCLES, default 100, SHALL set the auto-repeat period in cycles; legal range is 2 or more.
REQ-005 clk  input  1  base clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 pressed_pulse  input  1  one-cycle press event from the upstream debouncer.
REQ-008 released_pulse  input  1  one-cycle release event from the upstream debouncer.
REQ-009 short_pulse  output  1  one-cycle pulse: single short click confirmed.
REQ-010 long_pulse  output  1  one-cycle pulse: hold reached LONG_CYCLES.
REQ-011 double_pulse  output  1  one-cycle pulse: second press within DCLICK_CYCLES.
REQ-012 repeat_pulse  output  1  one-cycle pulse: auto-repeat tick during a long hold.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, HELD, GAP, WAIT_REL, LONG_HELD.
REQ-015 The state timer SHALL clear to 0 on every state change, increment otherwise, and saturate at its all-ones value; its width SHALL be $clog2(max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES))+1.
REQ-016 IDLE SHALL go to HELD on pressed_pulse and SHALL ignore released_pulse.
REQ-017 HELD SHALL go to GAP on released_pulse.
REQ-018 HELD SHALL go to LONG_HELD and assert long_pulse when timer==LONG_CYCLES-1 without released_pulse.
REQ-019 In HELD, when released_pulse coincides with timer==LONG_CYCLES-1, release SHALL win and the state SHALL go to GAP.
REQ-020 GAP SHALL go to WAIT_REL and assert double_pulse on pressed_pulse.
REQ-021 GAP SHALL go to IDLE and assert short_pulse when timer==DCLICK_CYCLES-1 without pressed_pulse.
REQ-022 In GAP, when pressed_pulse coincides with the GAP timeout, the press SHALL win and produce double_pulse.
REQ-023 WAIT_REL SHALL go to IDLE on released_pulse and SHALL generate no long or repeat events.
REQ-024 LONG_HELD SHALL go to IDLE on released_pulse; no short_pulse SHALL follow a long press.
REQ-025 If pressed_pulse and released_pulse are both high in the same cycle, pressed_pulse SHALL be ignored.
REQ-026 All outputs SHALL be registered and high for exactly one cycle, in the cycle after the deciding edge.
REQ-027 With pressed_pulse at cycle t0 and no release, long_pulse SHALL be high at cycle t0+LONG_CYCLES+1.
REQ-028 At most one of short_pulse, long_pulse, double_pulse and repeat_pulse SHALL be high in any cycle.

Reset
REQ-029 Asserting rst SHALL immediately, without a clock edge, force state IDLE, timer 0, and all outputs 0, including mid-gesture.
REQ-030 After rst deasserts, the block SHALL require a new pressed_pulse; a released_pulse arriving first SHALL be ignored.

Configuration
REQ-031 With macro PB_GESTURE_REPEAT_EN defined, LONG_HELD SHALL assert repeat_pulse each time timer==REPEAT_CYCLES-1; the timer SHALL then restart at 0, and release SHALL win on a coincident cycle.
REQ-032 Without PB_GESTURE_REPEAT_EN, the repeat logic SHALL be absent, repeat_pulse SHALL be tied to 0, and LONG_HELD SHALL only wait for release.

Verification (bench parameters LONG=8, DCLICK=5, REPEAT=4)
REQ-033 Press at t=10, release at t=13 -> short_pulse at t=19 only; busy is low from t=19.
REQ-034 Press at t=10, release at t=12, press at t=15, release at t=30 -> double_pulse at t=16 only; no short_pulse or long_pulse.
REQ-035 Press at t=10, release at t=40, REPEAT_EN defined -> long_pulse at t=19, repeat_pulse at t=23, 27, 31, 35, 39; no short_pulse.
REQ-036 Press at t=10, release at t=18 (coincides with the long terminal count) -> no long_pulse; short_pulse at t=24.
REQ-037 Press at t=10, rst pulsed at t=14, release at t=16 -> all outputs 0 from the rst assertion; no pulse at any time; busy low.
REQ-038 Same stimulus as REQ-035 without REPEAT_EN -> long_pulse at t=19 only; repeat_pulse constantly 0.
